// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcodes, FSM state encoding and instruction field positions
//           shared by the ALU issue controller and its register file.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int c_DATA_W  = 8;
    localparam int c_INSTR_W = 16;
    localparam int c_RADDR_W = 3;

    // ALU opcodes (alu_fsl)
    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_MUL = 4'b1110;
    localparam logic [3:0] c_OP_CMP = 4'b1111;

    // Instruction field positions
    localparam int c_LDI_BIT = 15;
    localparam int c_FSL_MSB = 14;
    localparam int c_FSL_LSB = 11;
    localparam int c_RD_MSB  = 10;
    localparam int c_RD_LSB  = 8;
    localparam int c_RS_MSB  = 7;
    localparam int c_RS_LSB  = 5;
    localparam int c_IMM_MSB = 7;
    localparam int c_IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_WBH  = 2'd3
    } state_t;

    function automatic logic [c_RADDR_W-1:0] fld_rd(input logic [c_INSTR_W-1:0] ins);
        return ins[c_RD_MSB:c_RD_LSB];
    endfunction

    function automatic logic [c_RADDR_W-1:0] fld_rs(input logic [c_INSTR_W-1:0] ins);
        return ins[c_RS_MSB:c_RS_LSB];
    endfunction

    function automatic logic [3:0] fld_fsl(input logic [c_INSTR_W-1:0] ins);
        return ins[c_FSL_MSB:c_FSL_LSB];
    endfunction

    function automatic logic [c_DATA_W-1:0] fld_imm(input logic [c_INSTR_W-1:0] ins);
        return ins[c_IMM_MSB:c_IMM_LSB];
    endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_regfile
// Brief   : NREG x 8 register file, one write port, three combinational reads.
// Rev     : 1.0  initial release
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [c_DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]       i_rd_addr,
    output logic [c_DATA_W-1:0] o_rd_data,
    input  logic [AW-1:0]       i_rs_addr,
    output logic [c_DATA_W-1:0] o_rs_data,
    input  logic [AW-1:0]       i_dbg_addr,
    output logic [c_DATA_W-1:0] o_dbg_data
);

    logic [c_DATA_W-1:0] w_mem [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic [c_DATA_W-1:0] r_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (i_we && (i_waddr == AW'(gi))) begin
                    r_q <= i_wdata;
                end
            end

            assign w_mem[gi] = r_q;
        end
    endgenerate

    assign o_rd_data  = w_mem[i_rd_addr];
    assign o_rs_data  = w_mem[i_rs_addr];
    assign o_dbg_data = w_mem[i_dbg_addr];

endmodule : alu_regfile

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Single-issue controller: accepts LDI/ALU instructions, sequences
//           operand fetch, result capture and writeback. Define
//           ALU_CTRL_MULHI_EN to write the MULTIPLY high byte to R[rd+1].
// Rev     : 1.0  initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [c_INSTR_W-1:0]      instr,
    output logic [c_DATA_W-1:0]       alu_a,
    output logic [c_DATA_W-1:0]       alu_b,
    output logic [3:0]                alu_fsl,
    input  logic [c_DATA_W-1:0]       alu_result,
    input  logic [c_DATA_W-1:0]       alu_mul_high,
    input  logic [3:0]                alu_sreg,
    output logic [3:0]                sreg,
    output logic                      done,
    input  logic [$clog2(NREG)-1:0]   dbg_addr,
    output logic [c_DATA_W-1:0]       dbg_data
);

    localparam int c_AW = $clog2(NREG);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_INSTR_W-1:0]  r_instr;
    logic [c_DATA_W-1:0]   r_res;
    logic [3:0]            r_flags;
    logic [3:0]            r_sreg;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_is_ldi;
    logic [3:0]            w_fsl;
    logic [c_AW-1:0]       w_rd;
    logic [c_AW-1:0]       w_rs;
    logic [c_DATA_W-1:0]   w_imm;
    logic [c_DATA_W-1:0]   w_rd_data;
    logic [c_DATA_W-1:0]   w_rs_data;

    logic                  w_we;
    logic [c_AW-1:0]       w_waddr;
    logic [c_DATA_W-1:0]   w_wdata;
    logic                  w_sreg_we;
    logic                  w_done_nxt;

    assign instr_ready = (r_state == ST_IDLE);
    assign w_accept    = instr_valid && instr_ready;

    // Operands and opcode come from the latched word only, so they stay put
    // from one accept edge to the next.
    assign w_is_ldi = r_instr[c_LDI_BIT];
    assign w_fsl    = fld_fsl(r_instr);
    assign w_rd     = fld_rd(r_instr);
    assign w_rs     = fld_rs(r_instr);
    assign w_imm    = fld_imm(r_instr);

    assign alu_a    = w_rd_data;
    assign alu_b    = w_rs_data;
    assign alu_fsl  = w_fsl;
    assign sreg     = r_sreg;
    assign done     = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= '0;
        end else if (w_accept) begin
            r_instr <= instr;
        end
    end

`ifdef ALU_CTRL_MULHI_EN
    logic [c_DATA_W-1:0] r_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
        end else if (r_state == ST_EXEC) begin
            r_hi <= alu_mul_high;
        end
    end
`else
    logic w_unused_mulhi;
    assign w_unused_mulhi = ^alu_mul_high;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res   <= '0;
            r_flags <= '0;
        end else if (r_state == ST_EXEC) begin
            r_res   <= alu_result;
            r_flags <= alu_sreg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sreg <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_sreg_we) begin
                r_sreg <= r_flags;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = w_rd;
        w_wdata     = r_res;
        w_sreg_we   = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // LDI has nothing to compute, so it skips straight to writeback.
                if (instr_valid) begin
                    w_state_nxt = instr[c_LDI_BIT] ? ST_WB : ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
                if (w_is_ldi) begin
                    w_we    = 1'b1;
                    w_wdata = w_imm;
                end else begin
                    w_sreg_we = 1'b1;
                    w_we      = (w_fsl != c_OP_CMP);
`ifdef ALU_CTRL_MULHI_EN
                    if (w_fsl == c_OP_MUL) begin
                        w_state_nxt = ST_WBH;
                        w_done_nxt  = 1'b0;
                    end
`endif
                end
            end
`ifdef ALU_CTRL_MULHI_EN
            ST_WBH: begin
                // rd+1 wraps naturally in the address width (R7 -> R0).
                w_we        = 1'b1;
                w_waddr     = w_rd + c_AW'(1);
                w_wdata     = r_hi;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    alu_regfile #(
        .NREG (NREG),
        .AW   (c_AW)
    ) u_regfile (
        .clk        (clk),
        .rst        (reset),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_rd_addr  (w_rd),
        .o_rd_data  (w_rd_data),
        .i_rs_addr  (w_rs),
        .o_rs_data  (w_rs_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

endmodule : alu_issue_ctrl

`default_nettype wire
